// File: rtl/p2_merge_pkg.sv
// Shared types and helpers for the p2 row merger.
//   entry_t : one queued partial product {val, col} at the default widths
//   state_t : merger control state
//   ptr_w() / qid_w() : pointer and queue-index widths for a given
//                       configuration; PTR_W / QID_W are the default-config values
package p2_merge_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int IDX_W_DEF   = 16;
   localparam int NQ_DEF      = 8;
   localparam int Q_DEPTH_DEF = 64;

   // Extra MSB on the queue pointers separates full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int qid_w(input int nq);
      return $clog2(nq);
   endfunction

   localparam int PTR_W = $clog2(Q_DEPTH_DEF) + 1;
   localparam int QID_W = $clog2(NQ_DEF);

   typedef struct packed {
      logic [DATA_W_DEF-1:0] val;
      logic [IDX_W_DEF-1:0]  col;
   } entry_t;

   typedef enum logic {
      S_FILL  = 1'b0,
      S_MERGE = 1'b1
   } state_t;

endpackage

// File: rtl/p2_merge_accum_fifo.sv
// merge_queue_fifo: one column-sorted segment queue of the row merger.
//   clk, rst   : clock, synchronous active-high reset (clears pointers)
//   push/data  : write one entry (ignored when full)
//   pop        : advance the head (ignored when empty)
//   flush      : clear both pointers; contents become invalid
//   head       : entry at the read pointer
//   empty/full : occupancy flags from the extra-bit pointer compare
//   last_one   : exactly one entry stored
module merge_queue_fifo
   import p2_merge_pkg::*;
#(
   parameter int W     = 48,
   parameter int DEPTH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full,
   output logic         last_one
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          do_push;
   logic          do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign last_one = ((wr_ptr_q - rd_ptr_q) == PW'(1));
   assign head     = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/p2_merge_accum.sv
// p2_merge_accum: buffers the partial-product segments of one output row
// into NQ sorted queues, then merges them by ascending column, summing equal
// columns, and streams the compressed row out with valid/ready.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : input handshake (ready only while filling)
//   in_val/in_row/in_col           : partial product entry
//   in_seg_last/in_last            : segment / row terminators
//   out_valid/out_ready            : output handshake (registered output)
//   out_val/out_row/out_col        : merged entry
//   out_last                       : final merged entry of the row
//   row_done                       : pulse the cycle after the row completes
//   busy                           : merging
//   err_overflow/err_seg           : sticky drop indicators
//
// state   | meaning
// S_FILL  | accepting entries, seg_idx selects the target queue
// S_MERGE | popping min-column heads into the output register
module p2_merge_accum
   import p2_merge_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int NQ      = NQ_DEF,
   parameter int Q_DEPTH = Q_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_val,
   input  logic [IDX_W-1:0]  in_row,
   input  logic [IDX_W-1:0]  in_col,
   input  logic              in_seg_last,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_val,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic              out_last,
   output logic              row_done,
   output logic              busy,
   output logic              err_overflow,
   output logic              err_seg
);

   localparam int QW    = qid_w(NQ);
   localparam int SEG_W = QW + 1;
   localparam int FW    = DATA_W + IDX_W;

   state_t              state_q, state_d;
   logic [SEG_W-1:0]    seg_idx_q, seg_idx_d;
   logic [IDX_W-1:0]    cur_row_q, cur_row_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_val_q, out_val_d;
   logic [IDX_W-1:0]    out_row_q, out_row_d;
   logic [IDX_W-1:0]    out_col_q, out_col_d;
   logic                out_last_q, out_last_d;
   logic                row_done_q, row_done_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_seg_q, err_seg_d;

   logic [NQ-1:0]       q_push, q_pop, q_empty, q_full, q_one;
   logic [FW-1:0]       q_head   [NQ];
   logic [IDX_W-1:0]    head_col [NQ];
   logic [DATA_W-1:0]   head_val [NQ];
   logic                q_flush;

   logic                in_xfer;
   logic                seg_ovf;
   logic [QW-1:0]       tgt;
   logic                tgt_full;

   logic [IDX_W-1:0]    min_col;
   logic                min_found;
   logic [NQ-1:0]       hit;
   logic [DATA_W-1:0]   sum;
   logic                drains_all;
   logic                all_empty;
   logic                out_xfer;
   logic                advance;
   logic                empty_row;
   logic                row_end;

   // ---------------------------------------------------------------- queues
   for (genvar g = 0; g < NQ; g++) begin : g_q
      merge_queue_fifo #(
         .W     (FW),
         .DEPTH (Q_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (q_push[g]),
         .push_data ({in_val, in_col}),
         .pop       (q_pop[g]),
         .flush     (q_flush),
         .head      (q_head[g]),
         .empty     (q_empty[g]),
         .full      (q_full[g]),
         .last_one  (q_one[g])
      );
      assign head_col[g] = q_head[g][IDX_W-1:0];
      assign head_val[g] = q_head[g][FW-1:IDX_W];
   end

   // ---------------------------------------------------------------- fill
   assign in_ready = (state_q == S_FILL);
   assign in_xfer  = in_valid && in_ready;
   // seg_idx saturates at NQ; anything arriving there has no queue.
   assign seg_ovf  = (seg_idx_q == SEG_W'(NQ));
   assign tgt      = seg_idx_q[QW-1:0];
   assign tgt_full = q_full[tgt];

   always_comb begin
      q_push = '0;
      for (int i = 0; i < NQ; i++) begin
         q_push[i] = in_xfer && !seg_ovf && !tgt_full && (tgt == QW'(i));
      end
   end

   // ---------------------------------------------------------------- merge
   always_comb begin
      min_col   = '0;
      min_found = 1'b0;
      for (int i = 0; i < NQ; i++) begin
         if (!q_empty[i] && (!min_found || (head_col[i] < min_col))) begin
            min_col   = head_col[i];
            min_found = 1'b1;
         end
      end
   end

   // drains_all: after popping the hit heads, no queue holds anything.
   always_comb begin
      hit        = '0;
      sum        = '0;
      drains_all = 1'b1;
      for (int i = 0; i < NQ; i++) begin
         hit[i] = !q_empty[i] && (head_col[i] == min_col);
         if (hit[i]) sum = sum + head_val[i];
         if (!q_empty[i] && !(hit[i] && q_one[i])) drains_all = 1'b0;
      end
   end

   assign all_empty = &q_empty;
   assign out_xfer  = out_valid_q && out_ready;
   assign advance   = (state_q == S_MERGE) && !all_empty && (!out_valid_q || out_ready);
   // Nothing queued and nothing pending: the whole row was dropped.
   assign empty_row = (state_q == S_MERGE) && all_empty && !out_valid_q;
   assign row_end   = (out_xfer && out_last_q) || empty_row;
   assign q_pop     = advance ? hit : '0;
   assign q_flush   = row_end;

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      seg_idx_d   = seg_idx_q;
      cur_row_d   = cur_row_q;
      out_valid_d = out_valid_q;
      out_val_d   = out_val_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      out_last_d  = out_last_q;
      row_done_d  = row_end;
      err_ovf_d   = err_ovf_q;
      err_seg_d   = err_seg_q;

      unique case (state_q)
         S_FILL: begin
            if (in_xfer) begin
               cur_row_d = in_row;
               if (seg_ovf)       err_seg_d = 1'b1;
               else if (tgt_full) err_ovf_d = 1'b1;
               if (in_last) begin
                  state_d   = S_MERGE;
                  seg_idx_d = '0;
               end else if (in_seg_last && !seg_ovf) begin
                  seg_idx_d = seg_idx_q + SEG_W'(1);
               end
            end
         end
         S_MERGE: begin
            if (row_end) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase

      if (advance) begin
         out_valid_d = 1'b1;
         out_val_d   = sum;
         out_col_d   = min_col;
         out_row_d   = cur_row_q;
         out_last_d  = drains_all;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FILL;
         seg_idx_q   <= '0;
         cur_row_q   <= '0;
         out_valid_q <= 1'b0;
         out_val_q   <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         row_done_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_seg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         seg_idx_q   <= seg_idx_d;
         cur_row_q   <= cur_row_d;
         out_valid_q <= out_valid_d;
         out_val_q   <= out_val_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
         row_done_q  <= row_done_d;
         err_ovf_q   <= err_ovf_d;
         err_seg_q   <= err_seg_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_val      = out_val_q;
   assign out_row      = out_row_q;
   assign out_col      = out_col_q;
   assign out_last     = out_last_q;
   assign row_done     = row_done_q;
   assign busy         = (state_q == S_MERGE);
   assign err_overflow = err_ovf_q;
   assign err_seg      = err_seg_q;

endmodule

// File: tb/tb_p2_merge_accum.sv
module tb_p2_merge_accum;

   localparam int NQ = 4;
   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_val;
   logic [15:0] in_row, in_col;
   logic        in_seg_last, in_last;
   logic        out_valid, out_ready;
   logic [31:0] out_val;
   logic [15:0] out_row, out_col;
   logic        out_last, row_done, busy, err_overflow, err_seg;

   always #5 clk = ~clk;

   p2_merge_accum #(
      .DATA_W  (32),
      .IDX_W   (16),
      .NQ      (NQ),
      .Q_DEPTH (QD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_val       (in_val),
      .in_row       (in_row),
      .in_col       (in_col),
      .in_seg_last  (in_seg_last),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_val      (out_val),
      .out_row      (out_row),
      .out_col      (out_col),
      .out_last     (out_last),
      .row_done     (row_done),
      .busy         (busy),
      .err_overflow (err_overflow),
      .err_seg      (err_seg)
   );

   typedef struct {
      logic [31:0] val;
      logic [15:0] row;
      logic [15:0] col;
      logic        last;
   } exp_t;

   typedef struct {
      logic [15:0] row;
      logic [15:0] col;
      logic [31:0] val;
      logic        sl;
      logic        l;
      logic        exp_err_seg;
      logic        exp_err_ovf;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;
   int   rd_count = 0;

   // reference model of one row: per-column wrap sums, ascending iteration
   logic [31:0] m_sum [int];
   int          m_seg = 0;
   int          m_cnt [NQ];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_sum.delete();
      m_seg = 0;
      for (int i = 0; i < NQ; i++) m_cnt[i] = 0;
   endtask

   task automatic model_entry(input logic [15:0] row, input logic [15:0] col,
                              input logic [31:0] val, input logic sl, input logic l);
      exp_t e;
      int   n, k;
      if (m_seg < NQ && m_cnt[m_seg] < QD) begin
         if (m_sum.exists(int'(col))) m_sum[int'(col)] = m_sum[int'(col)] + val;
         else                         m_sum[int'(col)] = val;
         m_cnt[m_seg]++;
      end
      if ((sl || l) && m_seg < NQ) m_seg++;
      if (l) begin
         n = m_sum.num();
         k = 0;
         foreach (m_sum[c]) begin
            e.val  = m_sum[c];
            e.col  = c[15:0];
            e.row  = row;
            e.last = (k == n - 1);
            sb_q.push_back(e);
            k++;
         end
         model_reset();
      end
   endtask

   // caller is 1 time unit after a rising edge
   task automatic send(input logic [15:0] row, input logic [15:0] col,
                       input logic [31:0] val, input logic sl, input logic l);
      in_valid    = 1'b1;
      in_row      = row;
      in_col      = col;
      in_val      = val;
      in_seg_last = sl | l;
      in_last     = l;
      chk("in_ready_fill", 64'(in_ready), 64'(1));
      model_entry(row, col, val, sl, l);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      in_seg_last = 1'b0;
      in_last     = 1'b0;
   endtask

   task automatic wait_row(input string name);
      int start;
      int n;
      start = rd_count;
      n = 0;
      while (rd_count == start && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (rd_count == start) begin
         checks++;
         failures++;
         $display("FAIL %s row_done_timeout actual=none required=pulse", name);
      end
      repeat (3) begin @(posedge clk); #1; end
      chk({name, "_row_done_count"}, 64'(rd_count - start), 64'(1));
      chk({name, "_sb_drained"}, 64'(sb_q.size()), 64'(0));
      chk({name, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({name, "_busy"}, 64'(busy), 64'(0));
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_out_valid_seen"}, 64'(out_valid), 64'(1));
   endtask

   // output monitor: scoreboard pop, hold stability, row_done timing
   logic prev_last_xfer = 1'b0;
   logic prev_hold      = 1'b0;
   exp_t held;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_last_xfer = 1'b0;
         prev_hold      = 1'b0;
      end else begin
         if (row_done) rd_count++;
         if (prev_last_xfer) chk("row_done_after_last", 64'(row_done), 64'(1));
         if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_val", 64'(out_val), 64'(held.val));
            chk("hold_col", 64'(out_col), 64'(held.col));
            chk("hold_last", 64'(out_last), 64'(held.last));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_busy", 64'(busy), 64'(1));
         end
         prev_last_xfer = 1'b0;
         prev_hold      = 1'b0;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=col %0d val %0h required=no output",
                        out_col, out_val);
            end else begin
               e = sb_q.pop_front();
               chk("out_val", 64'(out_val), 64'(e.val));
               chk("out_col", 64'(out_col), 64'(e.col));
               chk("out_row", 64'(out_row), 64'(e.row));
               chk("out_last", 64'(out_last), 64'(e.last));
            end
            prev_last_xfer = out_last;
         end else if (out_valid) begin
            prev_hold = 1'b1;
            held.val  = out_val;
            held.col  = out_col;
            held.row  = out_row;
            held.last = out_last;
         end
      end
   end

   function automatic vec_t mk(input logic [15:0] row, input logic [15:0] col,
                               input logic [31:0] val, input logic sl, input logic l,
                               input logic es, input logic eo);
      vec_t v;
      v.row = row; v.col = col; v.val = val; v.sl = sl; v.l = l;
      v.exp_err_seg = es; v.exp_err_ovf = eo;
      return v;
   endfunction

   initial begin
      // row 5: {c1:1,c3:2},{c2:4,c3:5} -> (1,1),(2,4),(3,7)
      tbl.push_back(mk(16'd5, 16'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd5, 16'd3, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd5, 16'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd5, 16'd3, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0));
      // row 7: every queue head at column 0 with all-ones -> wraps to FFFFFFFC
      tbl.push_back(mk(16'd7, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd7, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd7, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(16'd7, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));
      // row 9: five segments, the fifth is dropped
      tbl.push_back(mk(16'd9, 16'd0, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(16'd9, 16'd0, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(16'd9, 16'd1, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(16'd9, 16'd2, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(16'd9, 16'd0, 32'd100, 1'b1, 1'b1, 1'b1, 1'b0));
      // row 11: six entries into a depth-4 queue, last two dropped
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(16'd11, 16'(i), 32'(10 + i), 1'b0, (i == 5), 1'b1, 1'b1));

      rst = 1'b1; in_valid = 1'b0; in_val = '0; in_row = '0; in_col = '0;
      in_seg_last = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_row_done", 64'(row_done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err_overflow", 64'(err_overflow), 64'(0));
      chk("rst_err_seg", 64'(err_seg), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      foreach (tbl[i]) begin
         send(tbl[i].row, tbl[i].col, tbl[i].val, tbl[i].sl, tbl[i].l);
         if (tbl[i].l) begin
            wait_row($sformatf("row%0d", tbl[i].row));
            chk($sformatf("row%0d_err_seg", tbl[i].row), 64'(err_seg), 64'(tbl[i].exp_err_seg));
            chk($sformatf("row%0d_err_overflow", tbl[i].row), 64'(err_overflow),
                64'(tbl[i].exp_err_ovf));
         end
      end

      // backpressure: stall 3 cycles mid-merge
      send(16'd20, 16'd0, 32'd1, 1'b0, 1'b0);
      send(16'd20, 16'd2, 32'd2, 1'b0, 1'b0);
      send(16'd20, 16'd4, 32'd3, 1'b1, 1'b0);
      send(16'd20, 16'd1, 32'd4, 1'b0, 1'b0);
      send(16'd20, 16'd2, 32'd5, 1'b0, 1'b0);
      send(16'd20, 16'd5, 32'd6, 1'b1, 1'b1);
      wait_out_valid("stall");
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_row("stall");

      // reset while merging
      send(16'd30, 16'd0, 32'd1, 1'b0, 1'b0);
      send(16'd30, 16'd1, 32'd2, 1'b0, 1'b0);
      send(16'd30, 16'd2, 32'd3, 1'b1, 1'b1);
      wait_out_valid("midrst");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
      model_reset();
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_out_val", 64'(out_val), 64'(0));
      chk("midrst_out_col", 64'(out_col), 64'(0));
      chk("midrst_out_row", 64'(out_row), 64'(0));
      chk("midrst_out_last", 64'(out_last), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_err_seg", 64'(err_seg), 64'(0));
      chk("midrst_err_overflow", 64'(err_overflow), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));

      send(16'd31, 16'd3, 32'd7, 1'b1, 1'b0);
      send(16'd31, 16'd1, 32'd1, 1'b0, 1'b0);
      send(16'd31, 16'd3, 32'd8, 1'b1, 1'b1);
      wait_row("after_rst");
      chk("after_rst_err_seg", 64'(err_seg), 64'(0));
      chk("after_rst_err_overflow", 64'(err_overflow), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/p2_merge_accum.md
Name: p2_merge_accum

Overview:
Second-generation MatRaptor row merger for the SpGEMM accelerator. It buffers the partial-product segments of one output row of C into NQ column-sorted queues, then merges them by ascending column. Entries with equal columns are summed, and one compressed row is streamed downstream with valid/ready backpressure. The block sits between the partial-product generator and the C-row writer; one instance runs per PE.

Parameters:
DATA_W, 32, value width; sums wrap modulo 2^DATA_W
IDX_W, 16, row/column index width
NQ, 8, number of merge queues (power of 2, ≥2); also the maximum number of segments per row
Q_DEPTH, 64, entries per queue (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input entry valid
in_ready  out  1  block can accept an input entry
in_val  in  DATA_W  partial-product value
in_row  in  IDX_W  output row of C; constant within a row
in_col  in  IDX_W  column; strictly ascending within a segment
in_seg_last  in  1  last entry of the current segment
in_last  in  1  last entry of the row; implies in_seg_last
out_valid  out  1  merged entry valid
out_ready  in  1  downstream accepts the entry
out_val  out  DATA_W  accumulated value
out_row  out  IDX_W  row of the entry
out_col  out  IDX_W  column of the entry
out_last  out  1  final merged entry of the row
row_done  out  1  one-cycle pulse after the out_last entry transfers
busy  out  1  high in S_MERGE
err_overflow  out  1  sticky: an entry was dropped because its queue was full
err_seg  out  1  sticky: a row had more than NQ segments

Behaviour:
- Reset: all of the following are 0: out_valid, out_val, out_row, out_col, out_last, row_done, busy, err_overflow, err_seg, all queue pointers, and seg_idx. state=S_FILL. Reset mid-merge discards all queue contents and any pending output.
- Input transfer occurs when in_valid && in_ready. in_ready = (state==S_FILL). Nothing else gates in_ready: entries are never stalled, only dropped.
- S_FILL: each accepted entry is written to queue[seg_idx] and cur_row is captured.
  - in_seg_last: seg_idx increments.
  - seg_idx==NQ when a new segment's entry arrives: the entry is dropped and err_seg is set.
  - Target queue full: the entry is dropped and err_overflow is set.
  - in_last: transition to S_MERGE on the next cycle; seg_idx is cleared. This happens even if the in_last entry itself was dropped.
- S_MERGE: each cycle the output register is free or being drained (!out_valid || out_ready):
  - mincol = the minimum head column among non-empty queues.
  - Pop every head whose column equals mincol.
  - Load the output register with out_val = wrap-sum of those head values, out_col=mincol, out_row=cur_row, out_valid=1.
  - out_last=1 when all queues will be empty after the pop.
- Throughput is one merged entry per cycle under continuous out_ready. Output is registered, giving one cycle of latency from pop to out_valid.
- Output stays stable while out_valid && !out_ready.
- After the out_last transfer: row_done pulses the following cycle, state→S_FILL, and pointers are cleared.
- A row whose entries were all dropped (every queue empty on entry to S_MERGE): emit nothing, pulse row_done once, return to S_FILL.
- Equal columns across all NQ heads: all are popped and summed in a single output.
- The err_* bits clear only on rst.
- State machine: S_FILL → S_MERGE on an accepted in_last; S_MERGE → S_FILL after the out_last transfer or on the empty-row case.

Decomposition:
- Package p2_merge_pkg holds entry_t {val, col}, state_t {S_FILL, S_MERGE}, and the PTR_W/QID_W localparams.
- Sub-module merge_queue_fifo (one per queue, generate loop) provides:
  - push/pop/flush
  - head data
  - empty/full using an extra-bit pointer scheme.
- Min-select and adder are combinational in the top module.

Test Plan:
1. NQ=4, one row 5 with segments {c1:1,c3:2}, {c2:4,c3:5} → outputs (5,1,1), (5,2,4), (5,3,7); out_last on column 3; row_done pulses once.
2. All 4 queues have head column 0 with value 0xFFFFFFFF → a single output with col 0 and val 0xFFFFFFFC (wrap).
3. Hold out_ready=0 for 3 cycles mid-merge → out_* stable; no entries lost; order preserved.
4. 5 segments with NQ=4 → the 5th segment is dropped, err_seg=1, and the first 4 segments merge correctly.
5. Q_DEPTH=4 and a 6-entry segment → 4 entries are kept, err_overflow=1, and the row completes.
6. Assert rst mid-merge for 1 cycle → all outputs 0, in_ready=1 next cycle, and a following row merges cleanly.
